// File: rtl/pe_weight_loader.sv
// Row-weight injection transmitter: packs NUM_COLS serial weight beats into one
// row vector and strobes it into the PE grid for each row of a contiguous range.
module pe_weight_loader #(
  parameter int NUM_ROWS = 12,
  parameter int NUM_COLS = 14,
  parameter int DATA_W   = 16,
  parameter int ROW_ID_W = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [ROW_ID_W-1:0]                   first_row,
  input  logic [ROW_ID_W-1:0]                   num_rows,
  input  logic [DATA_W-1:0]                     w_data,
  input  logic                                  w_valid,
  output logic                                  w_ready,
  output logic [0:NUM_COLS-1][DATA_W-1:0]       row_weight_vals,
  output logic [ROW_ID_W-1:0]                   tag_row,
  output logic                                  valid_y,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err
);

  localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam logic [COL_W-1:0]    LAST_COL     = COL_W'(NUM_COLS - 1);
  localparam logic [ROW_ID_W:0]   ROW_LIMIT    = (ROW_ID_W + 1)'(NUM_ROWS);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FILL   = 2'd1;
  localparam logic [1:0] ST_ISSUE  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  logic [1:0]                        state;
  logic [1:0]                        state_next;
  logic [COL_W-1:0]                  col;
  logic [ROW_ID_W-1:0]               row_ptr;
  logic [ROW_ID_W-1:0]               rows_left;
  logic [0:NUM_COLS-1][DATA_W-1:0]   shadow;
  logic [0:NUM_COLS-1][DATA_W-1:0]   issue_vec;
  logic [ROW_ID_W:0]                 row_end;
  logic                              beat_acc;
  logic                              last_beat;
  logic                              start_idle;
  logic                              job_zero;
  logic                              job_bad;

  // w_ready is a registered copy of (state == ST_FILL), so it doubles as the accept qualifier
  assign beat_acc   = w_valid && w_ready;
  assign last_beat  = beat_acc && (col == LAST_COL);
  assign start_idle = start && (state == ST_IDLE);
  assign row_end    = {1'b0, first_row} + {1'b0, num_rows};
  assign job_zero   = (num_rows == '0);
  assign job_bad    = (row_end > ROW_LIMIT) || ({1'b0, first_row} >= ROW_LIMIT);

  // The final beat bypasses the shadow so the vector is issued the cycle after it is accepted
  always_comb begin
    issue_vec      = shadow;
    issue_vec[col] = w_data;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start && !job_zero && !job_bad) state_next = ST_FILL;
      ST_FILL:   if (last_beat) state_next = ST_ISSUE;
      ST_ISSUE:  state_next = (rows_left == ROW_ID_W'(1)) ? ST_FINISH : ST_FILL;
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      w_ready         <= 1'b0;
      busy            <= 1'b0;
      valid_y         <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      col             <= '0;
      row_ptr         <= '0;
      rows_left       <= '0;
      shadow          <= '0;
      row_weight_vals <= '0;
      tag_row         <= '0;
    end else begin
      state   <= state_next;
      w_ready <= (state_next == ST_FILL);
      busy    <= (state_next != ST_IDLE);
      valid_y <= last_beat;
      done    <= (state_next == ST_FINISH) || (start_idle && job_zero);
      err     <= start_idle && !job_zero && job_bad;

      if (start_idle && !job_zero && !job_bad) begin
        row_ptr   <= first_row;
        rows_left <= num_rows;
      end

      if (beat_acc) begin
        shadow[col] <= w_data;
        col         <= last_beat ? '0 : col + COL_W'(1);
      end

      if (last_beat) begin
        row_weight_vals <= issue_vec;
        tag_row         <= row_ptr;
      end

      if (state == ST_ISSUE) begin
        row_ptr   <= row_ptr + ROW_ID_W'(1);
        rows_left <= rows_left - ROW_ID_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pe_weight_loader.sv
// Directed bench for pe_weight_loader: row packing, tagging, job range checks,
// mid-job start/stall handling and reset abort.
module tb_pe_weight_loader;

  localparam int NR = 12;
  localparam int NC = 14;
  localparam int DW = 16;
  localparam int RW = 4;

  typedef logic [0:NC-1][DW-1:0] vec_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic [RW-1:0] first_row;
  logic [RW-1:0] num_rows;
  logic [DW-1:0] w_data;
  logic          w_valid;
  logic          w_ready;
  vec_t          row_weight_vals;
  logic [RW-1:0] tag_row;
  logic          valid_y;
  logic          busy;
  logic          done;
  logic          err;

  pe_weight_loader #(
    .NUM_ROWS(NR),
    .NUM_COLS(NC),
    .DATA_W(DW),
    .ROW_ID_W(RW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .first_row(first_row),
    .num_rows(num_rows),
    .w_data(w_data),
    .w_valid(w_valid),
    .w_ready(w_ready),
    .row_weight_vals(row_weight_vals),
    .tag_row(tag_row),
    .valid_y(valid_y),
    .busy(busy),
    .done(done),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run;
  int tests_failed;

  // Observation log, sampled on the falling edge
  int            cyc;
  int            last_acc_cyc;
  int            acc_cnt;
  int            done_cnt;
  int            done_cyc;
  int            done_nobusy;
  int            err_cnt;
  int            ready_cnt;
  logic [RW-1:0] vy_tag_q[$];
  vec_t          vy_vec_q[$];
  int            vy_cyc_q[$];
  int            vy_gap_q[$];

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (w_valid && w_ready) begin
        last_acc_cyc = cyc;
        acc_cnt++;
      end
      if (valid_y) begin
        vy_tag_q.push_back(tag_row);
        vy_vec_q.push_back(row_weight_vals);
        vy_cyc_q.push_back(cyc);
        vy_gap_q.push_back(cyc - last_acc_cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (!busy) done_nobusy++;
      end
      if (err) err_cnt++;
      if (w_ready) ready_cnt++;
    end
  end

  task automatic clear_mon();
    acc_cnt = 0; done_cnt = 0; done_cyc = 0; done_nobusy = 0;
    err_cnt = 0; ready_cnt = 0; last_acc_cyc = 0;
    vy_tag_q.delete(); vy_vec_q.delete(); vy_cyc_q.delete(); vy_gap_q.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int fr, input int nr);
    start = 1'b1; first_row = RW'(fr); num_rows = RW'(nr);
    step();
    start = 1'b0;
  endtask

  // Presents nbeats consecutive values from base; holds each beat until accepted
  task automatic feed(input int base, input int nbeats, input bit gap,
                      input int start_at, output bit timeout);
    int  i;
    int  t;
    bit  acc;
    i = 0; t = 0; timeout = 1'b0;
    while (i < nbeats) begin
      w_valid = gap ? ((t % 2) == 0) : 1'b1;
      w_data  = DW'(base + i);
      if (t == start_at) begin
        start = 1'b1; first_row = '0; num_rows = RW'(1);
      end else begin
        start = 1'b0;
      end
      acc = w_valid && w_ready;
      step();
      t++;
      if (acc) i++;
      if (t > 1000) begin
        timeout = 1'b1;
        break;
      end
    end
    w_valid = 1'b0;
    start   = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, output bit timeout);
    int n;
    n = 0;
    while (busy && n < maxc) begin
      step();
      n++;
    end
    timeout = busy;
    step();
  endtask

  function automatic vec_t make_vec(input int base);
    vec_t v;
    for (int c = 0; c < NC; c++) v[c] = DW'(base + c);
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests_run++;
      if ({w_ready, valid_y, busy, done, err} !== 5'b0) begin
        tests_failed++;
        $display("FAIL reset_ctrl cyc%0d: got %b expected 00000", k, {w_ready, valid_y, busy, done, err});
      end
      tests_run++;
      if (tag_row !== '0 || row_weight_vals !== '0) begin
        tests_failed++;
        $display("FAIL reset_data cyc%0d: tag %0h vec %0h expected 0", k, tag_row, row_weight_vals);
      end
    end
    step();
  endtask

  task automatic test_single_row();
    bit   to1, to2;
    vec_t exp;
    clear_mon();
    pulse_start(0, 1);
    tests_run++;
    if (busy !== 1'b1 || w_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_enter: busy %b w_ready %b expected 1 1", busy, w_ready);
    end
    feed(1, NC, 1'b0, -1, to1);
    wait_idle(50, to2);
    exp = make_vec(1);
    tests_run++;
    if (to1 || to2) begin
      tests_failed++;
      $display("FAIL single_timeout: feed %0d idle %0d expected 0 0", to1, to2);
    end
    tests_run++;
    if (vy_tag_q.size() !== 1) begin
      tests_failed++;
      $display("FAIL single_vy_count: got %0d expected 1", vy_tag_q.size());
    end else begin
      tests_run++;
      if (vy_tag_q[0] !== RW'(0) || vy_vec_q[0] !== exp) begin
        tests_failed++;
        $display("FAIL single_vec: tag %0d vec %0h expected 0 %0h", vy_tag_q[0], vy_vec_q[0], exp);
      end
      tests_run++;
      if (vy_gap_q[0] !== 1) begin
        tests_failed++;
        $display("FAIL single_latency: got %0d expected 1", vy_gap_q[0]);
      end
      tests_run++;
      if (done_cnt !== 1 || done_cyc !== vy_cyc_q[0] + 1 || done_nobusy !== 0) begin
        tests_failed++;
        $display("FAIL single_done: cnt %0d cyc %0d nobusy %0d expected 1 %0d 0",
                 done_cnt, done_cyc, done_nobusy, vy_cyc_q[0] + 1);
      end
    end
    tests_run++;
    if (busy !== 1'b0 || row_weight_vals !== exp || tag_row !== RW'(0)) begin
      tests_failed++;
      $display("FAIL single_hold: busy %b vec %0h tag %0d expected 0 %0h 0", busy, row_weight_vals, tag_row, exp);
    end
  endtask

  task automatic test_gapped_rows();
    bit to1, to2;
    clear_mon();
    pulse_start(10, 2);
    feed(100, 2 * NC, 1'b1, -1, to1);
    wait_idle(80, to2);
    tests_run++;
    if (to1 || to2 || vy_tag_q.size() !== 2) begin
      tests_failed++;
      $display("FAIL gap_count: timeouts %0d %0d vy %0d expected 0 0 2", to1, to2, vy_tag_q.size());
    end else begin
      tests_run++;
      if (vy_tag_q[0] !== RW'(10) || vy_tag_q[1] !== RW'(11)) begin
        tests_failed++;
        $display("FAIL gap_tags: got %0d %0d expected 10 11", vy_tag_q[0], vy_tag_q[1]);
      end
      tests_run++;
      if (vy_vec_q[0] !== make_vec(100) || vy_vec_q[1] !== make_vec(100 + NC)) begin
        tests_failed++;
        $display("FAIL gap_vecs: got %0h %0h expected %0h %0h", vy_vec_q[0], vy_vec_q[1],
                 make_vec(100), make_vec(100 + NC));
      end
      tests_run++;
      if (vy_gap_q[0] !== 1 || vy_gap_q[1] !== 1) begin
        tests_failed++;
        $display("FAIL gap_early_vy: gaps %0d %0d expected 1 1", vy_gap_q[0], vy_gap_q[1]);
      end
    end
    tests_run++;
    if (done_cnt !== 1 || err_cnt !== 0) begin
      tests_failed++;
      $display("FAIL gap_done: done %0d err %0d expected 1 0", done_cnt, err_cnt);
    end
  endtask

  task automatic test_job_checks();
    bit to1, to2;
    // 11+2 overruns the grid
    clear_mon();
    pulse_start(11, 2);
    for (int k = 0; k < 4; k++) step();
    tests_run++;
    if (err_cnt !== 1 || done_cnt !== 0 || ready_cnt !== 0 || vy_tag_q.size() !== 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL overrun_err: err %0d done %0d ready %0d vy %0d busy %b expected 1 0 0 0 0",
               err_cnt, done_cnt, ready_cnt, vy_tag_q.size(), busy);
    end
    // 4-bit sum that would wrap without the extra bit
    clear_mon();
    pulse_start(15, 15);
    for (int k = 0; k < 3; k++) step();
    tests_run++;
    if (err_cnt !== 1 || ready_cnt !== 0) begin
      tests_failed++;
      $display("FAIL wrap_err: err %0d ready %0d expected 1 0", err_cnt, ready_cnt);
    end
    // zero rows takes priority over an illegal first_row
    clear_mon();
    pulse_start(15, 0);
    for (int k = 0; k < 3; k++) step();
    tests_run++;
    if (done_cnt !== 1 || err_cnt !== 0 || ready_cnt !== 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_rows: done %0d err %0d ready %0d busy %b expected 1 0 0 0",
               done_cnt, err_cnt, ready_cnt, busy);
    end
    // last legal row exactly fills the grid
    clear_mon();
    pulse_start(11, 1);
    feed(200, NC, 1'b0, -1, to1);
    wait_idle(50, to2);
    tests_run++;
    if (to1 || to2 || err_cnt !== 0 || vy_tag_q.size() !== 1 || done_cnt !== 1) begin
      tests_failed++;
      $display("FAIL edge_row: timeouts %0d %0d err %0d vy %0d done %0d expected 0 0 0 1 1",
               to1, to2, err_cnt, vy_tag_q.size(), done_cnt);
    end else begin
      tests_run++;
      if (vy_tag_q[0] !== RW'(11) || vy_vec_q[0] !== make_vec(200)) begin
        tests_failed++;
        $display("FAIL edge_row_vec: tag %0d vec %0h expected 11 %0h", vy_tag_q[0], vy_vec_q[0], make_vec(200));
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to1, to2;
    clear_mon();
    pulse_start(2, 2);
    feed(300, 2 * NC, 1'b0, 5, to1);
    wait_idle(80, to2);
    tests_run++;
    if (to1 || to2 || err_cnt !== 0 || done_cnt !== 1 || acc_cnt !== 2 * NC) begin
      tests_failed++;
      $display("FAIL b2b_ctrl: timeouts %0d %0d err %0d done %0d acc %0d expected 0 0 0 1 %0d",
               to1, to2, err_cnt, done_cnt, acc_cnt, 2 * NC);
    end
    tests_run++;
    if (vy_tag_q.size() !== 2) begin
      tests_failed++;
      $display("FAIL b2b_vy_count: got %0d expected 2", vy_tag_q.size());
    end else begin
      tests_run++;
      if (vy_tag_q[0] !== RW'(2) || vy_tag_q[1] !== RW'(3)) begin
        tests_failed++;
        $display("FAIL b2b_tags: got %0d %0d expected 2 3", vy_tag_q[0], vy_tag_q[1]);
      end
      tests_run++;
      if (vy_vec_q[0] !== make_vec(300) || vy_vec_q[1] !== make_vec(300 + NC)) begin
        tests_failed++;
        $display("FAIL b2b_order: got %0h %0h expected %0h %0h", vy_vec_q[0], vy_vec_q[1],
                 make_vec(300), make_vec(300 + NC));
      end
      tests_run++;
      if (vy_cyc_q[1] - vy_cyc_q[0] !== NC + 1) begin
        tests_failed++;
        $display("FAIL b2b_rate: got %0d expected %0d", vy_cyc_q[1] - vy_cyc_q[0], NC + 1);
      end
    end
  endtask

  task automatic test_reset_abort();
    bit to1, to2;
    clear_mon();
    pulse_start(0, 3);
    feed(400, NC + 7, 1'b0, -1, to1);
    rst = 1'b1;
    step();
    @(negedge clk);
    tests_run++;
    if (to1 || {w_ready, valid_y, busy, done, err} !== 5'b0) begin
      tests_failed++;
      $display("FAIL abort_ctrl: feed_to %0d got %b expected 00000", to1, {w_ready, valid_y, busy, done, err});
    end
    tests_run++;
    if (tag_row !== '0 || row_weight_vals !== '0) begin
      tests_failed++;
      $display("FAIL abort_data: tag %0d vec %0h expected 0 0", tag_row, row_weight_vals);
    end
    step();
    rst = 1'b0;
    clear_mon();
    for (int k = 0; k < 40; k++) step();
    tests_run++;
    if (done_cnt !== 0 || vy_tag_q.size() !== 0 || ready_cnt !== 0) begin
      tests_failed++;
      $display("FAIL abort_quiet: done %0d vy %0d ready %0d expected 0 0 0", done_cnt, vy_tag_q.size(), ready_cnt);
    end
    clear_mon();
    pulse_start(5, 1);
    feed(500, NC, 1'b0, -1, to1);
    wait_idle(50, to2);
    tests_run++;
    if (to1 || to2 || vy_tag_q.size() !== 1 || done_cnt !== 1) begin
      tests_failed++;
      $display("FAIL restart_ctrl: timeouts %0d %0d vy %0d done %0d expected 0 0 1 1",
               to1, to2, vy_tag_q.size(), done_cnt);
    end else begin
      tests_run++;
      if (vy_tag_q[0] !== RW'(5) || vy_vec_q[0] !== make_vec(500)) begin
        tests_failed++;
        $display("FAIL restart_vec: tag %0d vec %0h expected 5 %0h", vy_tag_q[0], vy_vec_q[0], make_vec(500));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run = 0; tests_failed = 0; cyc = 0;
    rst = 1'b1; start = 1'b0; first_row = '0; num_rows = '0;
    w_data = '0; w_valid = 1'b0;
    clear_mon();
    test_reset();
    test_single_row();
    test_gapped_rows();
    test_job_checks();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
